// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the mem_responder block.
package mem_responder_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam int WORD_W     = 16;
   localparam int DEF_LAT    = 2;
   localparam int DEF_ADDR_W = 8;
   localparam int CNT_W      = 4;

endpackage

// File: rtl/mem_responder_array.sv
// Word storage for mem_responder: one synchronous write port, one combinational read port,
// asynchronous active-low clear of every word.
module mem_responder_array import mem_responder_pkg::*; #(
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WORD_W-1:0] wdata,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WORD_W-1:0] rdata
);

   logic [WORD_W-1:0] mem [2**ADDR_W];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < 2**ADDR_W; i++) mem[i] <= '0;
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Fixed-latency memory responder: IDLE -> BUSY (LAT cycles) -> DONE one-cycle strobe.
// Define MEM_RESPONDER_ALIGN_CHK_EN to answer odd byte addresses with err=1 instead of accessing storage.
module mem_responder import mem_responder_pkg::*; #(
   parameter int LAT    = DEF_LAT,
   parameter int ADDR_W = DEF_ADDR_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable,
   input  logic              wr,
   input  logic [WORD_W-1:0] addr,
   input  logic [WORD_W-1:0] data_in,
   output logic [WORD_W-1:0] data_out,
   output logic              stall,
   output logic              done,
   output logic              err
);

   state_t            state, state_nxt;
   logic [CNT_W-1:0]  cnt;
   logic              cap_wr;
   logic              cap_odd;
   logic [ADDR_W-1:0] cap_idx;
   logic [WORD_W-1:0] cap_data;
   logic              accept;
   logic              access;
   logic              misaligned;
   logic              mem_we;
   logic [WORD_W-1:0] rdata;
   logic              addr_unused;

`ifdef MEM_RESPONDER_ALIGN_CHK_EN
   assign misaligned  = cap_odd;
   assign addr_unused = ^addr[WORD_W-1:ADDR_W+1];
`else
   assign misaligned  = 1'b0;
   assign addr_unused = ^{addr[WORD_W-1:ADDR_W+1], cap_odd};
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (enable) state_nxt = BUSY;
         BUSY:    if (cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      accept = 1'b0;
      access = 1'b0;
      mem_we = 1'b0;
      stall  = 1'b0;
      case (state)
         IDLE: begin
            accept = enable;
            stall  = enable;
         end
         BUSY: begin
            stall  = 1'b1;
            access = (cnt == '0);
            mem_we = access && cap_wr && !misaligned;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   cnt <= '0;
      else if (accept)            cnt <= CNT_W'(LAT - 1);
      else if (state == BUSY && cnt != '0) cnt <= cnt - 1'b1;
   end

   // Request snapshot; later input changes cannot disturb an access in flight.
   always_ff @(posedge clk) begin
      if (accept) begin
         cap_wr   <= wr;
         cap_idx  <= addr[ADDR_W:1];
         cap_odd  <= addr[0];
         cap_data <= data_in;
      end
   end

   mem_responder_array #(.ADDR_W(ADDR_W)) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (mem_we),
      .waddr (cap_idx),
      .wdata (cap_data),
      .raddr (cap_idx),
      .rdata (rdata)
   );

   // Response registers are nonzero only during the DONE cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         done     <= 1'b0;
         err      <= 1'b0;
         data_out <= '0;
      end else begin
         done     <= access;
         err      <= access && misaligned;
         data_out <= (access && !cap_wr && !misaligned) ? rdata : '0;
      end
   end

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: cycle-level behavioural model with per-cycle compare, directed literal
// checks, and randomized traffic. Works with and without MEM_RESPONDER_ALIGN_CHK_EN.
module tb_mem_responder;

   localparam int LAT    = 2;
   localparam int ADDR_W = 8;
   localparam int DEPTH  = 1 << ADDR_W;
`ifdef MEM_RESPONDER_ALIGN_CHK_EN
   localparam bit ALIGN = 1'b1;
`else
   localparam bit ALIGN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        enable, wr;
   logic [15:0] addr, data_in;
   logic [15:0] data_out;
   logic        stall, done, err;
   logic        en1, en15;
   logic        l1_done, l15_done;
   logic [15:0] l1_data_unused, l15_data_unused;
   logic        l1_stall_unused, l15_stall_unused, l1_err_unused, l15_err_unused;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   mem_responder #(.LAT(LAT), .ADDR_W(ADDR_W)) dut (
      .clk(clk), .rst(rst), .enable(enable), .wr(wr), .addr(addr), .data_in(data_in),
      .data_out(data_out), .stall(stall), .done(done), .err(err)
   );

   mem_responder #(.LAT(1), .ADDR_W(ADDR_W)) dut_l1 (
      .clk(clk), .rst(rst), .enable(en1), .wr(wr), .addr(addr), .data_in(data_in),
      .data_out(l1_data_unused), .stall(l1_stall_unused), .done(l1_done), .err(l1_err_unused)
   );

   mem_responder #(.LAT(15), .ADDR_W(ADDR_W)) dut_l15 (
      .clk(clk), .rst(rst), .enable(en15), .wr(wr), .addr(addr), .data_in(data_in),
      .data_out(l15_data_unused), .stall(l15_stall_unused), .done(l15_done), .err(l15_err_unused)
   );

   function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endfunction

   // Behavioural model: a request seen while free completes LAT+1 cycles later; next one may start after that.
   logic [15:0] mdl_mem [DEPTH];
   int          cyc        = 0;
   int          resp_cycle = -1;
   int          next_free  = 0;
   logic [15:0] resp_data  = '0;
   logic        resp_err   = 1'b0;
   logic        e_done, e_err, e_stall;
   logic [15:0] e_data;
   int          idx;

   always @(negedge clk) begin
      e_done = rst && (cyc == resp_cycle);
      e_data = e_done ? resp_data : 16'h0000;
      e_err  = e_done && resp_err;
      if (!rst || cyc >= next_free) e_stall = enable;
      else                          e_stall = (cyc != resp_cycle);
      chk("done", 32'(done), 32'(e_done));
      chk("data_out", 32'(data_out), 32'(e_data));
      chk("err", 32'(err), 32'(e_err));
      chk("stall", 32'(stall), 32'(e_stall));

      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mdl_mem[i] = 16'h0000;
         resp_cycle = -1;
         next_free  = cyc + 1;
      end else if (enable && cyc >= next_free) begin
         idx        = (int'(addr) / 2) % DEPTH;
         resp_cycle = cyc + LAT + 1;
         next_free  = cyc + LAT + 2;
         resp_data  = 16'h0000;
         resp_err   = 1'b0;
         if (ALIGN && addr[0]) resp_err = 1'b1;
         else if (wr)          mdl_mem[idx] = data_in;
         else                  resp_data = mdl_mem[idx];
      end
      cyc++;
   end

   // Called at posedge+#1 with the DUT idle; returns cycles from request to done.
   task automatic do_req(input logic w, input logic [15:0] a, input logic [15:0] d,
                         output int lat, output logic [15:0] q, output logic e);
      lat = -1; q = '0; e = 1'b0;
      enable = 1'b1; wr = w; addr = a; data_in = d;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(negedge clk);
         if (done) begin lat = k; q = data_out; e = err; end
         @(posedge clk); #1;
         enable = 1'b0;
      end
   endtask

   task automatic do_lat(input bit fifteen, output int lat);
      lat = -1;
      wr  = 1'b0;
      if (fifteen) en15 = 1'b1; else en1 = 1'b1;
      for (int k = 0; k < 40 && lat < 0; k++) begin
         @(negedge clk);
         if (fifteen ? l15_done : l1_done) lat = k;
         @(posedge clk); #1;
         en1 = 1'b0; en15 = 1'b0;
      end
   endtask

   int          lat;
   logic [15:0] q;
   logic        e;
   int          nd, ns;
   bit          prev_done, back_to_back;

   initial begin
      rst = 1'b0; enable = 1'b0; wr = 1'b0; addr = '0; data_in = '0; en1 = 1'b0; en15 = 1'b0;
      @(negedge clk);
      chk("reset_done", 32'(done), 32'd0);
      chk("reset_data", 32'(data_out), 32'd0);
      chk("reset_err", 32'(err), 32'd0);
      chk("reset_stall_idle", 32'(stall), 32'd0);
      @(posedge clk); #1;
      enable = 1'b1;
      @(negedge clk);
      chk("reset_stall_follows_enable", 32'(stall), 32'd1);
      @(posedge clk); #1;
      rst = 1'b1;

      // First request accepted right after reset release.
      do_req(1'b1, 16'h0010, 16'hBEEF, lat, q, e);
      chk("wr_latency", 32'(lat), 32'd3);
      chk("wr_resp_data", 32'(q), 32'h0);
      do_req(1'b0, 16'h0010, 16'h0000, lat, q, e);
      chk("rd_latency", 32'(lat), 32'd3);
      chk("rd_data", 32'(q), 32'hBEEF);
      chk("rd_err", 32'(e), 32'd0);

      do_req(1'b1, 16'h0002, 16'h1234, lat, q, e);
      do_req(1'b0, 16'h0202, 16'h0000, lat, q, e);
      chk("alias_rd_data", 32'(q), 32'h1234);

      do_req(1'b1, 16'h0002, 16'hA5A5, lat, q, e);
      do_req(1'b0, 16'h0003, 16'h0000, lat, q, e);
      chk("odd_latency", 32'(lat), 32'd3);
      chk("odd_rd_data", 32'(q), ALIGN ? 32'h0 : 32'hA5A5);
      chk("odd_rd_err", 32'(e), ALIGN ? 32'd1 : 32'd0);
      do_req(1'b0, 16'h0002, 16'h0000, lat, q, e);
      chk("odd_storage_kept", 32'(q), 32'hA5A5);

      // Reset during BUSY of a write.
      enable = 1'b1; wr = 1'b1; addr = 16'h0004; data_in = 16'h00FF;
      @(posedge clk); #1;
      enable = 1'b0;
      rst = 1'b0;
      nd = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (done) nd++;
         @(posedge clk); #1;
         if (k == 3) rst = 1'b1;
      end
      chk("abort_no_done", 32'(nd), 32'd0);
      do_req(1'b0, 16'h0004, 16'h0000, lat, q, e);
      chk("abort_rd_data", 32'(q), 32'h0);
      do_req(1'b0, 16'h0010, 16'h0000, lat, q, e);
      chk("reset_cleared_word", 32'(q), 32'h0);

      // Enable held high with alternating write/read.
      enable = 1'b1; addr = 16'h0020; wr = 1'b1;
      nd = 0; ns = 0; prev_done = 1'b0; back_to_back = 1'b0;
      for (int k = 0; k < 4 * (LAT + 2); k++) begin
         data_in = 16'(k);
         @(negedge clk);
         if (done) nd++;
         if (stall) ns++;
         if (done && prev_done) back_to_back = 1'b1;
         prev_done = done;
         @(posedge clk); #1;
         wr = ~wr;
      end
      enable = 1'b0;
      chk("burst_done_count", 32'(nd), 32'd4);
      chk("burst_stall_count", 32'(ns), 32'd12);
      chk("burst_no_back_to_back", 32'(back_to_back), 32'd0);

      do_lat(1'b0, lat);
      chk("lat1_latency", 32'(lat), 32'd2);
      do_lat(1'b1, lat);
      chk("lat15_latency", 32'(lat), 32'd16);

      for (int k = 0; k < 3000; k++) begin
         rst     = ($urandom_range(0, 99) != 0);
         enable  = ($urandom_range(0, 3) != 0);
         wr      = 1'($urandom_range(0, 1));
         addr    = 16'($urandom) & (($urandom_range(0, 1) != 0) ? 16'hFE07 : 16'hFFFF);
         data_in = 16'($urandom);
         @(posedge clk); #1;
      end
      rst = 1'b1; enable = 1'b0;
      repeat (LAT + 4) @(posedge clk);
      #1;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
